// File: rtl/game_window_gen_pkg.sv
// game_config: shared types and defaults for the 3x3 window generator.
//   DEF_FIELD_W / DEF_FIELD_H : default field size in cells
//   FLUSH_LEN                 : dead flush beats after the last cell (default field)
//   win_t                     : neighbours[row][col], row 0 = y-1, col 0 = x-1
//   state_t                   : IDLE / RUN / FLUSH
//   edge_mask()               : clears window cells that fall outside the field
package game_config;

    localparam int DEF_FIELD_W = 64;
    localparam int DEF_FIELD_H = 48;
    localparam int FLUSH_LEN   = DEF_FIELD_W + 1;

    typedef logic [3:0][3:0] win_t;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    // Cells beyond the field edge are dead. The same masking also hides
    // stale line-buffer data from an earlier or aborted frame, and the
    // wrap-around of the raster into the neighbouring row.
    function automatic win_t edge_mask(input win_t w, input logic left,
                                       input logic right, input logic top,
                                       input logic bottom);
        win_t m;
        m    = w;
        m[3] = '0;
        for (int r = 0; r < 4; r++) begin
            m[r][3] = 1'b0;
            if (left)  m[r][0] = 1'b0;
            if (right) m[r][2] = 1'b0;
        end
        if (top)    m[0] = '0;
        if (bottom) m[2] = '0;
        return m;
    endfunction

endpackage

// File: rtl/game_window_gen_if.sv
// Stream interface of the window generator.
//   cell_in / cell_in_vld / sof : raster-order cell stream (producer -> block)
//   in_rdy                      : block accepts a beat this cycle
//   win / win_vld / win_x/win_y : 3x3 window and its centre (block -> consumer)
//   frame_done                  : pulses with the last window of a frame
// master = producer/consumer side, slave = the generator.
interface game_window_gen_if #(
    parameter int FIELD_W = 64,
    parameter int FIELD_H = 48
);
    import game_config::*;

    logic                       cell_in;
    logic                       cell_in_vld;
    logic                       sof;
    logic                       in_rdy;
    win_t                       win;
    logic                       win_vld;
    logic [$clog2(FIELD_W)-1:0] win_x;
    logic [$clog2(FIELD_H)-1:0] win_y;
    logic                       frame_done;

    modport master (
        output cell_in, cell_in_vld, sof,
        input  in_rdy, win, win_vld, win_x, win_y, frame_done
    );

    modport slave (
        input  cell_in, cell_in_vld, sof,
        output in_rdy, win, win_vld, win_x, win_y, frame_done
    );

endinterface

// File: rtl/game_line_buffer.sv
// One-bit delay line of DEPTH beats, advancing only when en is high.
//   clk  : clock
//   en   : shift one beat
//   din  : bit entering the line
//   dout : bit that entered DEPTH enabled beats ago
// Contents are not reset; callers mask anything stale.
module game_line_buffer #(
    parameter int DEPTH = 64
) (
    input  logic clk,
    input  logic en,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] taps;

    always_ff @(posedge clk) begin
        if (en) taps <= {taps[DEPTH-2:0], din};
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/game_window_gen.sv
// Streaming 3x3 neighbourhood generator for a FIELD_W x FIELD_H life field.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : game_window_gen_if.slave (cell stream in, window stream out)
// Beat k feeds column {line2, line1, cell} into a 3-column shift register;
// the window centred on k-(FIELD_W+1) is masked at the field edges and
// registered, so win_vld follows the completing beat by one cycle. After
// the last cell, FIELD_W+1 dead flush beats drain the remaining windows.
module game_window_gen
    import game_config::*;
#(
    parameter int FIELD_W = DEF_FIELD_W,
    parameter int FIELD_H = DEF_FIELD_H
) (
    input logic           clk,
    input logic           rst,
    game_window_gen_if.slave bus
);

    localparam int N         = FIELD_W * FIELD_H;
    localparam int KW        = $clog2(N + 1);
    localparam int XW        = $clog2(FIELD_W);
    localparam int YW        = $clog2(FIELD_H);
    localparam int FLUSH_CYC = FIELD_W + 1;

    localparam logic [KW-1:0] K_FIRST = KW'(FIELD_W + 1);  // first beat that completes a window
    localparam logic [KW-1:0] K_LAST  = KW'(N - 1);
    localparam logic [KW-1:0] F_LAST  = KW'(FLUSH_CYC - 1);
    localparam logic [XW-1:0] X_LAST  = XW'(FIELD_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(FIELD_H - 1);

    state_t        state;
    logic [KW-1:0] k;
    logic [KW-1:0] fcnt;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    win_t          sr;
    win_t          nw;

    logic          in_rdy_q;
    win_t          win_q;
    logic          win_vld_q;
    logic [XW-1:0] win_x_q;
    logic [YW-1:0] win_y_q;
    logic          frame_done_q;

    logic acc, step, emit, din, l1_out, l2_out;

    assign acc = bus.cell_in_vld && in_rdy_q;
    assign din = (state == FLUSH) ? 1'b0 : bus.cell_in;

    // step: a beat enters the pipeline; emit: that beat completes a window.
    always_comb begin
        step = 1'b0;
        emit = 1'b0;
        case (state)
            IDLE:  step = acc && bus.sof;
            RUN: begin
                step = acc;
                emit = acc && !bus.sof && (k >= K_FIRST);
            end
            FLUSH: begin
                step = 1'b1;
                emit = 1'b1;
            end
            default: ;
        endcase
    end

    game_line_buffer #(.DEPTH(FIELD_W)) u_line1 (
        .clk  (clk),
        .en   (step),
        .din  (din),
        .dout (l1_out)
    );

    game_line_buffer #(.DEPTH(FIELD_W)) u_line2 (
        .clk  (clk),
        .en   (step),
        .din  (l1_out),
        .dout (l2_out)
    );

    // Shift register contents after this beat; col 2 is the newest column.
    always_comb begin
        nw = '0;
        for (int r = 0; r < 3; r++) begin
            nw[r][0] = sr[r][1];
            nw[r][1] = sr[r][2];
        end
        nw[0][2] = l2_out;
        nw[1][2] = l1_out;
        nw[2][2] = din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            k            <= '0;
            fcnt         <= '0;
            cx           <= '0;
            cy           <= '0;
            sr           <= '0;
            in_rdy_q     <= 1'b0;
            win_q        <= '0;
            win_vld_q    <= 1'b0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            win_vld_q    <= 1'b0;
            frame_done_q <= 1'b0;
            in_rdy_q     <= 1'b1;

            if (step) sr <= nw;

            if (emit) begin
                win_q     <= edge_mask(nw, cx == '0, cx == X_LAST, cy == '0, cy == Y_LAST);
                win_vld_q <= 1'b1;
                win_x_q   <= cx;
                win_y_q   <= cy;
                if (cx == X_LAST) begin
                    cx <= '0;
                    cy <= (cy == Y_LAST) ? '0 : cy + 1'b1;
                end else begin
                    cx <= cx + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (acc && bus.sof) begin
                        k     <= KW'(1);
                        cx    <= '0;
                        cy    <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (acc) begin
                        if (bus.sof) begin
                            // restart; line buffers keep stale rows, top-row mask hides them
                            k  <= KW'(1);
                            cx <= '0;
                            cy <= '0;
                        end else if (k == K_LAST) begin
                            state    <= FLUSH;
                            fcnt     <= '0;
                            in_rdy_q <= 1'b0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    in_rdy_q <= 1'b0;
                    if (fcnt == F_LAST) begin
                        state        <= IDLE;
                        in_rdy_q     <= 1'b1;
                        frame_done_q <= 1'b1;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_rdy     = in_rdy_q;
    assign bus.win        = win_q;
    assign bus.win_vld    = win_vld_q;
    assign bus.win_x      = win_x_q;
    assign bus.win_y      = win_y_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_game_window_gen.sv
// Directed bench for game_window_gen on a 4x3 field.
module tb_game_window_gen;
    import game_config::*;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    localparam logic [11:0] F_DEAD = 12'h000;
    localparam logic [11:0] F_ONE  = 12'h020;  // single live cell at (1,1)
    localparam logic [11:0] F_ALL  = 12'hFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    game_window_gen_if #(.FIELD_W(W), .FIELD_H(H)) bus ();

    game_window_gen #(.FIELD_W(W), .FIELD_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        win_t w;
        int   x;
        int   y;
        bit   fd;
        int   c;
    } obs_t;

    obs_t q[$];
    int   cyc    = 0;
    int   rdy_lo = 0;
    int   fd_all = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.win_vld)
                q.push_back('{bus.win, int'(bus.win_x), int'(bus.win_y), bus.frame_done, cyc});
            if (!bus.in_rdy)    rdy_lo <= rdy_lo + 1;
            if (bus.frame_done) fd_all <= fd_all + 1;
        end
    end

    typedef struct {
        logic [11:0] f;
        bit          gap;
        int          sx;
        int          sy;
        logic [15:0] exp;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Window straight from the definition: neighbours outside the field are dead.
    function automatic win_t model(input logic [11:0] f, input int x, input int y);
        win_t w;
        int   xx, yy;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                xx = x + c - 1;
                yy = y + r - 1;
                if (xx >= 0 && xx < W && yy >= 0 && yy < H) w[r][c] = f[yy*W + xx];
            end
        return w;
    endfunction

    task automatic send(input logic [11:0] f, input bit gap, input int nbeats, output int sc);
        int b;
        b  = 0;
        sc = 0;
        while (!bus.in_rdy && b < 50) begin
            @(posedge clk); #1;
            b++;
        end
        chk("in_rdy before frame", 32'(bus.in_rdy), 32'd1);
        for (int i = 0; i < nbeats; i++) begin
            if (gap && i > 0) begin
                bus.cell_in_vld = 1'b0;
                bus.sof         = 1'b0;
                @(posedge clk); #1;
            end
            bus.cell_in_vld = 1'b1;
            bus.sof         = (i == 0);
            bus.cell_in     = f[i];
            @(posedge clk); #1;
            if (i == 0) sc = cyc;
        end
        bus.cell_in_vld = 1'b0;
        bus.sof         = 1'b0;
        bus.cell_in     = 1'b0;
    endtask

    task automatic wait_win(input int target);
        int b;
        b = 0;
        while (q.size() < target && b < 60) begin
            @(posedge clk); #1;
            b++;
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_frame(input string nm, input int base, input logic [11:0] f,
                               input bit gap, input int sc);
        logic [11:0] fdm;
        int          sp, ex;
        win_t        ew;
        fdm = '0;
        sp  = 0;
        for (int i = 0; i < N; i++) begin
            if (base + i < q.size()) begin
                ew = model(f, i % W, i / W);
                chk($sformatf("%s window %0d", nm, i),
                    {8'(q[base+i].x), 8'(q[base+i].y), 16'(q[base+i].w)},
                    {8'(i % W), 8'(i / W), 16'(ew)});
                fdm[i] = q[base+i].fd;
                if (i > 0) begin
                    ex = (gap && i <= 6) ? 2 : 1;
                    if (q[base+i].c - q[base+i-1].c != ex) sp++;
                end
            end
        end
        chk({nm, " frame_done position"}, 32'(fdm), 32'h800);
        chk({nm, " window spacing"}, 32'(sp), 32'd0);
        if (base < q.size())
            chk({nm, " first-window latency"}, 32'(q[base].c - sc), gap ? 32'd10 : 32'd5);
    endtask

    initial begin
        int base, base2, rb, fb, sc, sc2;

        vt[0] = '{F_DEAD, 1'b0, 2, 1, 16'h0000};
        vt[1] = '{F_ONE,  1'b0, 0, 0, 16'h0400};
        vt[2] = '{F_ONE,  1'b0, 1, 1, 16'h0020};
        vt[3] = '{F_ONE,  1'b0, 2, 2, 16'h0001};
        vt[4] = '{F_ALL,  1'b0, 0, 0, 16'h0660};
        vt[5] = '{F_ALL,  1'b0, 1, 1, 16'h0777};
        vt[6] = '{F_ALL,  1'b0, 3, 2, 16'h0033};
        vt[7] = '{F_ONE,  1'b1, 0, 0, 16'h0400};
        vt[8] = '{F_ALL,  1'b1, 1, 1, 16'h0777};

        rst             = 1'b1;
        bus.cell_in     = 1'b0;
        bus.cell_in_vld = 1'b0;
        bus.sof         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_rdy", 32'(bus.in_rdy), 32'd0);
        chk("reset win_vld", 32'(bus.win_vld), 32'd0);
        chk("reset win", 32'(bus.win), 32'd0);
        chk("reset coords", {16'(bus.win_x), 16'(bus.win_y)}, 32'd0);
        chk("reset frame_done", 32'(bus.frame_done), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("in_rdy after release", 32'(bus.in_rdy), 32'd1);

        for (int v = 0; v < 9; v++) begin
            base = q.size();
            rb   = rdy_lo;
            fb   = fd_all;
            send(vt[v].f, vt[v].gap, N, sc);
            wait_win(base + N);
            chk($sformatf("vec%0d window count", v), 32'(q.size() - base), 32'(N));
            check_frame($sformatf("vec%0d", v), base, vt[v].f, vt[v].gap, sc);
            if (base + vt[v].sy*W + vt[v].sx < q.size())
                chk($sformatf("vec%0d spot (%0d,%0d)", v, vt[v].sx, vt[v].sy),
                    32'(q[base + vt[v].sy*W + vt[v].sx].w), 32'(vt[v].exp));
            chk($sformatf("vec%0d in_rdy low cycles", v), 32'(rdy_lo - rb), 32'd5);
            chk($sformatf("vec%0d frame_done count", v), 32'(fd_all - fb), 32'd1);
        end

        // sof again at beat 6: only the one old window completed before the restart
        base = q.size();
        fb   = fd_all;
        send(F_ALL, 1'b0, 6, sc);
        send(F_ONE, 1'b0, N, sc2);
        wait_win(base + N + 1);
        chk("abort window count", 32'(q.size() - base), 32'(N + 1));
        if (base < q.size())
            chk("abort old window", {8'(q[base].x), 8'(q[base].y), 16'(q[base].w)},
                {8'd0, 8'd0, 16'h0660});
        check_frame("abort new", base + 1, F_ONE, 1'b0, sc2);
        chk("abort frame_done count", 32'(fd_all - fb), 32'd1);

        // reset while flushing
        send(F_ALL, 1'b0, N, sc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        fb  = fd_all;
        rst = 1'b1;
        #1;
        chk("mid-flush rst win_vld", 32'(bus.win_vld), 32'd0);
        chk("mid-flush rst win", 32'(bus.win), 32'd0);
        chk("mid-flush rst coords/done", {8'(bus.win_x), 8'(bus.win_y), 8'(bus.frame_done), 8'(bus.in_rdy)}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("no frame_done from aborted frame", 32'(fd_all - fb), 32'd0);
        base2 = q.size();
        fb    = fd_all;
        send(F_ONE, 1'b0, N, sc);
        wait_win(base2 + N);
        chk("post-rst window count", 32'(q.size() - base2), 32'(N));
        check_frame("post-rst", base2, F_ONE, 1'b0, sc);
        chk("post-rst frame_done count", 32'(fd_all - fb), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_window_gen.md
# game_window_gen

Streaming 3x3 neighbourhood generator sitting directly upstream of the per-cell simulation stage. It accepts the current generation as a raster-order stream of 1-bit cells and emits one 3x3 window per cell, centre cell included. Cells outside the field are dead; there is no toroidal wrap. Every window carries its centre coordinates, so the downstream stage's result can be written back to the next-generation field.

## Interface
Parameters:
- FIELD_W, default 64: field width in cells; must be ≥ 3.
- FIELD_H, default 48: field height in cells; must be ≥ 2.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- cell_in  in  1  cell state, 1 = alive.
- cell_in_vld  in  1  cell_in is valid this cycle.
- sof  in  1  qualified by cell_in_vld; marks cell (0,0) of a frame.
- in_rdy  out  1  block accepts a beat this cycle; a beat transfers when cell_in_vld && in_rdy.
- win  out  [3:0][3:0]  window in neighbours[row][col] layout: row 0 = y-1, col 0 = x-1, [1][1] = centre. Only bits [2:0] of each row are used; bit 3 and row 3 are tied 0.
- win_vld  out  1  win, win_x and win_y are valid. Single-cycle pulse per window.
- win_x  out  $clog2(FIELD_W)  centre column.
- win_y  out  $clog2(FIELD_H)  centre row.
- frame_done  out  1  one-cycle pulse with the last window of a frame.

## Operation
- Beat index k = y*FIELD_W + x, counted over accepted beats. N = FIELD_W*FIELD_H.
- Accepted beat k emits the window centred on cell k-(FIELD_W+1) when that value is ≥ 0.
- After beat N-1, the block inserts FIELD_W+1 internal dead flush beats. These emit the remaining windows, so exactly N windows are produced per frame, in raster order.
- Storage is two FIELD_W-bit line buffers (rows y-1 and y-2) plus a 3x3 shift register fed by {line2, line1, cell_in}.
- Edge masking is applied after the shift register:
  - cx==0: col 0 forced to 0.
  - cx==FIELD_W-1: col 2 forced to 0.
  - cy==0: row 0 forced to 0.
  - cy==FIELD_H-1: row 2 forced to 0.
- States:
  - IDLE: in_rdy=1. Non-sof beats are dropped. An accepted sof beat loads k=0 and moves to RUN.
  - RUN: in_rdy=1. Beat N-1 moves to FLUSH.
  - FLUSH: in_rdy=0. An internal beat every cycle; after FLUSH_LEN = FIELD_W+1 beats, frame_done pulses and the state returns to IDLE.
- A sof beat accepted in RUN aborts the current frame: the line buffers are not cleared, but their stale contents are masked out by the top-row rule; k restarts at 0 and no windows are emitted for the aborted remainder.
- Counters use $clog2(N+1) bits. Coordinate counters (x, y, cx, cy) wrap at FIELD_W and FIELD_H, with no modulo arithmetic.

## Timing
- Reset values: in_rdy=0 while rst is high, 1 on the first cycle after release; win=0, win_vld=0, win_x=0, win_y=0, frame_done=0; state=IDLE; line buffers are don't-care.
- Latency: win_vld rises on the cycle after the accepted beat (or flush beat) that completes the window. All outputs are registered.
- Throughput: one window per cycle in RUN with continuous input and in FLUSH. Gaps in cell_in_vld produce matching gaps in win_vld.
- FLUSH lasts exactly FIELD_W+1 cycles. frame_done coincides with the win_vld of window N-1. The earliest next sof is accepted the cycle after that.
- No backpressure from downstream: the consumer must take every win_vld beat.
- An rst assertion mid-frame clears all outputs immediately and discards the frame.

## Structure
- Package game_config holds:
  - FIELD_W/FIELD_H defaults.
  - typedef win_t = logic [3:0][3:0].
  - state enum {IDLE, RUN, FLUSH}.
  - localparam FLUSH_LEN = FIELD_W+1.
- One sub-module, game_line_buffer: a FIELD_W-deep 1-bit shift delay with enable, instantiated twice and chained.

## Test plan
- FIELD_W=4, FIELD_H=3, all cells dead -> 12 windows; win all 0; coordinates (0,0)..(3,2) in raster order; frame_done pulses with window (3,2).
- Same field, single live cell at (1,1) -> the 8 windows centred on its neighbours each have exactly one bit set at the mirrored position (e.g. centre (0,0) gives win[2][2]=1); the window at (1,1) gives win[1][1]=1.
- All cells alive -> window (0,0) has only [1][1], [1][2], [2][1], [2][2] set; window (1,1) has all 9 bits set; window (3,2) has rows 0-1, cols 0-1.
- cell_in_vld toggling 1,0,1,0 -> win_vld sequence is the same pattern delayed; contents are identical to the continuous run; in_rdy is 0 for exactly 5 cycles in FLUSH.
- sof re-asserted at beat 6 -> no window is emitted for an old centre after the restart; the new frame yields 12 correct windows.
- rst pulsed during FLUSH -> outputs are 0 immediately; a later sof frame produces correct output, with no frame_done from the aborted frame.
